mem_2_axi4_lite: RTL
====================

Name: mem_2_axi4_lite

Overview:
- Bridges the simple single-cycle mem_if request interface to an AXI4-Lite initiator (manager) port.
- Mirrors axi4_lite_2_mem: a memory-style requester (sequencer, DMA, test stimulus) drives AXI4-Lite subordinates such as axi4_lite_2_mem itself.
- Exactly one transaction is in flight at a time.
- Completion is signalled by pulses back on the mem side.

Parameters:
AXI_ALEN, 32, AXI address width
MEM_ALEN, 8, mem-side word address width
DLEN, 32, data width (32 or 64)
SLEN, DLEN/8, strobe width
BASE_ADDR, 0, byte address added to every translated address

Ports:
clk  in  1  clock (the only clock)
rst  in  1  reset, asynchronous, active-high
mem_ready  out  1  bridge idle; requests accepted only when high
mem_wen  in  1  write request strobe
mem_waddr  in  MEM_ALEN  write word address
mem_wdata  in  DLEN  write data
mem_ren  in  1  read request strobe
mem_raddr  in  MEM_ALEN  read word address
mem_rdata  out  DLEN  read data
mem_rvalid  out  1  one-cycle read-complete pulse
mem_wdone  out  1  one-cycle write-complete pulse
mem_err  out  1  one-cycle pulse with rvalid/wdone when resp != OKAY
axi_awvalid/awready/awaddr/awprot  out/in/out/out  1/1/AXI_ALEN/3  write address channel
axi_wvalid/wready/wdata/wstrb  out/in/out/out  1/1/DLEN/SLEN  write data channel
axi_bvalid/bready/bresp  in/out/in  1/1/2  write response channel
axi_arvalid/arready/araddr/arprot  out/in/out/out  1/1/AXI_ALEN/3  read address channel
axi_rvalid/rready/rdata/rresp  in/out/in/in  1/1/DLEN/2  read data channel

Behaviour:
- One clock (clk). Reset rst is asynchronous and active-high.
- Reset values: all AXI valid/ready outputs 0; awaddr, araddr, wdata, mem_rdata 0; wstrb all ones; mem_rvalid, mem_wdone, mem_err 0; state IDLE. mem_ready = (state==IDLE) && !rd_pend.
- Address translation: axi_addr = BASE_ADDR + (mem_addr << $clog2(SLEN)), truncated to AXI_ALEN bits.
- awprot and arprot are tied to 3'b000.
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP.
- IDLE, mem_wen=1 at cycle N: capture address and data; go to WR_REQ. axi_awvalid and axi_wvalid rise at N+1.
- IDLE, mem_ren=1 (no wen): capture address; go to RD_REQ. axi_arvalid rises at N+1.
- Simultaneous wen and ren in IDLE: both are captured. The write executes first. rd_pend is set, and RD_REQ is entered on write completion. This gives read-after-write ordering.
- WR_REQ: awvalid and wvalid are held independently until their own ready is seen; each drops the cycle after its handshake.
  - Either order, or both in the same cycle, is legal.
  - Go to WR_RESP once both handshakes are done.
- WR_RESP: bready=1. On bvalid&&bready: bready drops; mem_wdone pulses the next cycle; mem_err pulses with it if bresp != 2'b00.
  - Next state is RD_REQ if rd_pend, else IDLE.
  - The pending read's arvalid rises in the cycle after the b handshake.
- RD_REQ: arvalid is held until arready, then go to RD_RESP.
- RD_RESP: rready=1. On rvalid&&rready: mem_rdata <= axi_rdata; mem_rvalid pulses the next cycle; mem_err pulses if rresp != 2'b00. Clear rd_pend; go to IDLE.
  - mem_rdata holds until the next read completes.
- Valid outputs never deassert before their handshake; AXI address and data outputs are stable while valid is high.
- Requests are ignored while mem_ready=0; a requester that drives them then must retry.
- Minimum latency with zero-wait subordinate: write request to mem_wdone = 3 cycles; read request to mem_rvalid = 3 cycles.
- Reset mid-transaction: everything returns to reset values immediately, and no completion pulse is issued.

Optional Feature:
- Macro: MEM_2_AXI4_LITE_WSTRB_EN.
- Defined: adds input port mem_wstrb [SLEN]. It is captured with mem_wdata and driven onto axi_wstrb.
- Undefined: the port is absent and axi_wstrb is constant all ones.

Decomposition:
- axi4_lite_pkg: resp_t enum (OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3) and PROT_DEFAULT=3'b000.
- Local enum state_t holds the FSM states.
- No sub-module; a single flat module.
- Bench pairs it with axi4_lite_2_mem plus a reference memory.

Test Plan:
- Write: wen, waddr=8'h05, wdata=32'hDEADBEEF, zero-wait subordinate -> awaddr=32'h14, wdata=DEADBEEF, wstrb=4'hF; mem_wdone 3 cycles later; mem_err=0.
- Read back: ren, raddr=8'h05 -> araddr=32'h14; mem_rvalid pulse with mem_rdata=32'hDEADBEEF.
- Skewed channels: wready 4 cycles before awready -> wvalid drops after its handshake, awvalid held; exactly one wdone after bvalid.
- Simultaneous: wen (addr 3, data 32'h12345678) and ren (addr 3) in one cycle -> write completes first; then read returns 32'h12345678; mem_ready low throughout.
- Error: subordinate returns rresp=2'b10 with rdata=32'hBAD0BAD0 -> mem_rvalid and mem_err pulse together; mem_rdata=32'hBAD0BAD0.
- Reset: assert rst while awvalid is high and awready is held low -> awvalid=0 asynchronously; no wdone pulse; mem_ready=1 after release.

Source files
------------

// File: rtl/mem_2_axi4_lite_pkg.sv
// Shared AXI4-Lite definitions for the mem_if to AXI4-Lite bridge.
// Response codes, the fixed protection value and a response classifier.
package mem_2_axi4_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  localparam logic [2:0] PROT_DEFAULT = 3'b000;

  // Anything other than OKAY is reported to the requester as an error.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp_t'(resp) != OKAY;
  endfunction

endpackage

// File: rtl/mem_2_axi4_lite_if.sv
// Bundle of the mem_if request side and the AXI4-Lite manager side of the bridge.
// mem_wstrb exists only when MEM_2_AXI4_LITE_WSTRB_EN is defined.
interface mem_2_axi4_lite_if #(
  parameter int unsigned AXI_ALEN = 32,
  parameter int unsigned MEM_ALEN = 8,
  parameter int unsigned DLEN     = 32
);
  localparam int unsigned SLEN = DLEN / 8;

  // mem side
  logic                mem_ready;
  logic                mem_wen;
  logic [MEM_ALEN-1:0] mem_waddr;
  logic [DLEN-1:0]     mem_wdata;
`ifdef MEM_2_AXI4_LITE_WSTRB_EN
  logic [SLEN-1:0]     mem_wstrb;
`endif
  logic                mem_ren;
  logic [MEM_ALEN-1:0] mem_raddr;
  logic [DLEN-1:0]     mem_rdata;
  logic                mem_rvalid;
  logic                mem_wdone;
  logic                mem_err;

  // AXI side
  logic                axi_awvalid;
  logic                axi_awready;
  logic [AXI_ALEN-1:0] axi_awaddr;
  logic [2:0]          axi_awprot;
  logic                axi_wvalid;
  logic                axi_wready;
  logic [DLEN-1:0]     axi_wdata;
  logic [SLEN-1:0]     axi_wstrb;
  logic                axi_bvalid;
  logic                axi_bready;
  logic [1:0]          axi_bresp;
  logic                axi_arvalid;
  logic                axi_arready;
  logic [AXI_ALEN-1:0] axi_araddr;
  logic [2:0]          axi_arprot;
  logic                axi_rvalid;
  logic                axi_rready;
  logic [DLEN-1:0]     axi_rdata;
  logic [1:0]          axi_rresp;

  // master: the bridge itself
  modport master (
    output mem_ready,
    input  mem_wen, mem_waddr, mem_wdata,
`ifdef MEM_2_AXI4_LITE_WSTRB_EN
    input  mem_wstrb,
`endif
    input  mem_ren, mem_raddr,
    output mem_rdata, mem_rvalid, mem_wdone, mem_err,
    output axi_awvalid, axi_awaddr, axi_awprot,
    input  axi_awready,
    output axi_wvalid, axi_wdata, axi_wstrb,
    input  axi_wready,
    input  axi_bvalid, axi_bresp,
    output axi_bready,
    output axi_arvalid, axi_araddr, axi_arprot,
    input  axi_arready,
    input  axi_rvalid, axi_rdata, axi_rresp,
    output axi_rready
  );

  // slave: the environment (requester plus AXI subordinate)
  modport slave (
    input  mem_ready,
    output mem_wen, mem_waddr, mem_wdata,
`ifdef MEM_2_AXI4_LITE_WSTRB_EN
    output mem_wstrb,
`endif
    output mem_ren, mem_raddr,
    input  mem_rdata, mem_rvalid, mem_wdone, mem_err,
    input  axi_awvalid, axi_awaddr, axi_awprot,
    output axi_awready,
    input  axi_wvalid, axi_wdata, axi_wstrb,
    output axi_wready,
    output axi_bvalid, axi_bresp,
    input  axi_bready,
    input  axi_arvalid, axi_araddr, axi_arprot,
    output axi_arready,
    output axi_rvalid, axi_rdata, axi_rresp,
    input  axi_rready
  );

endinterface

// File: rtl/mem_2_axi4_lite.sv
// Bridge from the single-cycle mem_if request port to an AXI4-Lite manager, one transaction at a time.
// Optional byte strobes on the mem side: define MEM_2_AXI4_LITE_WSTRB_EN.
module mem_2_axi4_lite
  import mem_2_axi4_lite_pkg::*;
#(
  parameter int unsigned AXI_ALEN  = 32,
  parameter int unsigned MEM_ALEN  = 8,
  parameter int unsigned DLEN      = 32,
  parameter logic [63:0] BASE_ADDR = 64'h0
) (
  input logic                clk,
  input logic                rst,
  mem_2_axi4_lite_if.master  bus
);

  localparam int unsigned SLEN   = DLEN / 8;
  localparam int unsigned ASHIFT = $clog2(SLEN);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4
  } state_t;

  // Word address to byte address, offset by BASE_ADDR and truncated to the bus width.
  function automatic logic [AXI_ALEN-1:0] xlate(input logic [MEM_ALEN-1:0] addr);
    return AXI_ALEN'(BASE_ADDR + (64'(addr) << ASHIFT));
  endfunction

  state_t              state;
  logic                rd_pend;
  logic                ready_q;
  logic                awvalid_q;
  logic                wvalid_q;
  logic                bready_q;
  logic                arvalid_q;
  logic                rready_q;
  logic [AXI_ALEN-1:0] awaddr_q;
  logic [AXI_ALEN-1:0] araddr_q;
  logic [DLEN-1:0]     wdata_q;
  logic [DLEN-1:0]     rdata_q;
  logic                rvalid_q;
  logic                wdone_q;
  logic                err_q;
`ifdef MEM_2_AXI4_LITE_WSTRB_EN
  logic [SLEN-1:0]     wstrb_q;
`endif

  // A write channel counts as done once its handshake has happened, now or earlier.
  logic aw_done;
  logic w_done;
  assign aw_done = !awvalid_q || bus.axi_awready;
  assign w_done  = !wvalid_q  || bus.axi_wready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rd_pend   <= 1'b0;
      ready_q   <= 1'b1;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awaddr_q  <= '0;
      araddr_q  <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      wdone_q   <= 1'b0;
      err_q     <= 1'b0;
`ifdef MEM_2_AXI4_LITE_WSTRB_EN
      wstrb_q   <= '1;
`endif
    end else begin
      rvalid_q <= 1'b0;
      wdone_q  <= 1'b0;
      err_q    <= 1'b0;

      unique case (state)
        IDLE: begin
          // A write wins; a simultaneous read is parked in rd_pend behind it.
          if (bus.mem_wen) begin
            awaddr_q  <= xlate(bus.mem_waddr);
            wdata_q   <= bus.mem_wdata;
`ifdef MEM_2_AXI4_LITE_WSTRB_EN
            wstrb_q   <= bus.mem_wstrb;
`endif
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            ready_q   <= 1'b0;
            state     <= WR_REQ;
            if (bus.mem_ren) begin
              araddr_q <= xlate(bus.mem_raddr);
              rd_pend  <= 1'b1;
            end
          end else if (bus.mem_ren) begin
            araddr_q  <= xlate(bus.mem_raddr);
            arvalid_q <= 1'b1;
            ready_q   <= 1'b0;
            state     <= RD_REQ;
          end
        end

        WR_REQ: begin
          if (awvalid_q && bus.axi_awready) awvalid_q <= 1'b0;
          if (wvalid_q && bus.axi_wready)   wvalid_q  <= 1'b0;
          if (aw_done && w_done) begin
            bready_q <= 1'b1;
            state    <= WR_RESP;
          end
        end

        WR_RESP: begin
          if (bus.axi_bvalid) begin
            bready_q <= 1'b0;
            wdone_q  <= 1'b1;
            err_q    <= resp_is_err(bus.axi_bresp);
            if (rd_pend) begin
              arvalid_q <= 1'b1;
              state     <= RD_REQ;
            end else begin
              ready_q <= 1'b1;
              state   <= IDLE;
            end
          end
        end

        RD_REQ: begin
          if (bus.axi_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state     <= RD_RESP;
          end
        end

        RD_RESP: begin
          if (bus.axi_rvalid) begin
            rready_q <= 1'b0;
            rdata_q  <= bus.axi_rdata;
            rvalid_q <= 1'b1;
            err_q    <= resp_is_err(bus.axi_rresp);
            rd_pend  <= 1'b0;
            ready_q  <= 1'b1;
            state    <= IDLE;
          end
        end

        default: begin
          state   <= IDLE;
          ready_q <= !rd_pend;
        end
      endcase
    end
  end

  assign bus.mem_ready   = ready_q;
  assign bus.mem_rdata   = rdata_q;
  assign bus.mem_rvalid  = rvalid_q;
  assign bus.mem_wdone   = wdone_q;
  assign bus.mem_err     = err_q;

  assign bus.axi_awvalid = awvalid_q;
  assign bus.axi_awaddr  = awaddr_q;
  assign bus.axi_awprot  = PROT_DEFAULT;
  assign bus.axi_wvalid  = wvalid_q;
  assign bus.axi_wdata   = wdata_q;
`ifdef MEM_2_AXI4_LITE_WSTRB_EN
  assign bus.axi_wstrb   = wstrb_q;
`else
  assign bus.axi_wstrb   = '1;
`endif
  assign bus.axi_bready  = bready_q;
  assign bus.axi_arvalid = arvalid_q;
  assign bus.axi_araddr  = araddr_q;
  assign bus.axi_arprot  = PROT_DEFAULT;
  assign bus.axi_rready  = rready_q;

endmodule
